rsp_buff: RTL

//  Response buffer: read-side counterpart of the AXI command FIFO path. The ctrl block pushes

---
 rtl/rsp_buff.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rsp_buff.sv
// Response buffer: ENT_NUM-deep FIFO filled by ctrl, drained one word per AXI read.
// Define RSP_BUFF_STATUS_EN to make reads with addr[3:2]==2'b01 return the fill count.
module rsp_buff #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ENT_NUM    = 4,
    parameter logic [1:0]  RSP_REGION = 2'b01,
    parameter int unsigned WAIT_MAX   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_rsp_buff_vld,
    input  logic [DATA_WIDTH-1:0] ctrl_rsp_buff_data,
    output logic                  rsp_buff_ctrl_rdy,
    input  logic                  axi_rd_vld,
    input  logic [ADDR_WIDTH-1:0] axi_rd_addr,
    input  logic [1:0]            axi_rd_region,
    output logic                  axi_rd_busy,
    output logic                  axi_rd_done,
    output logic [DATA_WIDTH-1:0] axi_rd_data,
    output logic                  axi_rd_err
);

    localparam int unsigned PTR_W = (ENT_NUM > 1) ? $clog2(ENT_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(ENT_NUM + 1);
    localparam int unsigned TMR_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ENT_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ENT_NUM);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   mem_q [ENT_NUM];

    logic push;
    logic pop;
    logic not_full;
    logic not_empty;
    logic rd_qual;
    logic is_status;
    logic unused_addr;

    assign not_full  = (count_q != CNT_FULL);
    assign not_empty = (count_q != '0);
    assign push      = ctrl_rsp_buff_vld & not_full;
    assign rd_qual   = axi_rd_vld & (axi_rd_region == RSP_REGION) & (state_q == StIdle);

    // Only addr[3:2] matters, and only with the status feature built in.
    assign unused_addr = ^axi_rd_addr;

`ifdef RSP_BUFF_STATUS_EN
    assign is_status = (axi_rd_addr[3:2] == 2'b01);
`else
    assign is_status = 1'b0;
`endif

    // Read FSM; pop is asserted in the cycle the head entry is latched.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (rd_qual) begin
                    if (is_status) begin
                        data_d  = DATA_WIDTH'(count_q);
                        err_d   = 1'b0;
                        state_d = StResp;
                    end else if (not_empty) begin
                        pop     = 1'b1;
                        data_d  = mem_q[rd_ptr_q];
                        err_d   = 1'b0;
                        state_d = StResp;
                    end else begin
                        timer_d = '0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (timer_q == TMR_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StResp: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ctrl_rsp_buff_data;
        end
    end

    assign rsp_buff_ctrl_rdy = not_full;
    assign axi_rd_busy       = (state_q != StIdle);
    assign axi_rd_done       = done_q;
    assign axi_rd_data       = data_q;
    assign axi_rd_err        = err_q;

endmodule
